avalon_bus_arbiter: RTL and testbench
=====================================

# avalon_bus_arbiter

Two-master, one-slave Avalon-MM arbiter that shares the single 32-bit data/instruction RAM between the `mips_cpu_bus` master (M0) and a debug/inspection master (M1), such as a post-run memory dump engine or a loader. It sits between the masters and the `RAM_32x64k_avalon` slave. It grants whole transactions round-robin, forwards the slave `waitrequest`/`readdata` handshake to the granted master, and bounds every transaction with a watchdog so that a hung slave cannot stall the CPU indefinitely.

## Interface
- `ADDR_W`, 32, address width of all three ports
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`
- `MAX_WAIT`, 255, maximum number of granted cycles with `waitrequest` high before the watchdog aborts the transaction (range 1..65535)

Ports:
- `clk` in 1: single clock, all state changes on posedge
- `reset` in 1: synchronous, active-high
- `m0_address` in ADDR_W; `m0_read` in 1; `m0_write` in 1; `m0_writedata` in DATA_W; `m0_byteenable` in DATA_W/8: CPU request
- `m0_waitrequest` out 1; `m0_readdata` out DATA_W: CPU response
- `m1_*`: identical set for the debug master
- `s_address` out ADDR_W; `s_read` out 1; `s_write` out 1; `s_writedata` out DATA_W; `s_byteenable` out DATA_W/8: to the slave
- `s_waitrequest` in 1; `s_readdata` in DATA_W: from the slave
- `grant` out 2: one-hot current owner (`01`=M0, `10`=M1, `00`=idle)
- `timeout_err` out 1: sticky; set by a watchdog abort, cleared only by reset

## Operation
- A master requests when `read|write` is high. Masters must hold all request signals stable until they sample `waitrequest` low.
- Asserting `read` and `write` together is illegal. It is treated as a write.
- States are IDLE, BUSY_M0 and BUSY_M1.
- **IDLE:**
  - `s_read`, `s_write` = 0; both `m*_waitrequest` = 1.
  - One requester: go to its BUSY state.
  - Both requesting: grant the master that was not granted last. The `last` pointer resets to M1, so M0 wins the first tie.
- **BUSY_Mx:**
  - Slave outputs are a combinational mux of Mx's request.
  - `mx_waitrequest` = `s_waitrequest`; `mx_readdata` = `s_readdata`.
  - The other master sees `waitrequest` = 1 and `readdata` = 0.
- **Completion:** at a posedge in BUSY_Mx where Mx has `read|write` high and `s_waitrequest` = 0, the transaction is done. Then `last` <= x, the state goes to IDLE and the wait counter clears.
- **Request withdrawn:** if Mx drops `read|write` while granted (protocol violation), go to IDLE next cycle. `last` is not updated.
- **Watchdog:**
  - A 16-bit wait counter increments on each BUSY cycle with `s_waitrequest` = 1.
  - When the counter equals `MAX_WAIT`, in the next cycle (ABORT_Mx, sub-phase of BUSY):
    - `s_read`/`s_write` = 0;
    - `mx_waitrequest` = 0, `mx_readdata` = 0;
    - `timeout_err` <= 1.
  - Then go to IDLE and set `last` <= x.
- `grant` reflects the registered state. It is `00` in IDLE.

## Timing
- Reset values:
  - state IDLE, `last` = M1, counter 0, `timeout_err` 0, `grant` 00;
  - all `s_*` outputs 0;
  - `m*_waitrequest` 1, `m*_readdata` 0.
- **Arbitration latency:** 1 cycle. A request first seen at edge N is presented to the slave during cycle N+1.
- **Zero-wait slave:** a transaction occupies 2 cycles (IDLE + BUSY). Back-to-back requests from the same master always have one IDLE cycle between them. That cycle is where the other master can win.
- **Abort:** the master sees `waitrequest` low exactly `MAX_WAIT`+1 cycles after grant.
- **Reset mid-transaction:** return to IDLE at the reset edge and drop all `s_*` strobes. No completion is signalled to any master.
- **Simultaneous completion and new request from the other master:** the new request is granted through IDLE on the following cycle. There is no same-cycle handover.

## Structure
- Package `mips_bus_pkg` holds:
  - `arb_state_t` enum {IDLE, BUSY_M0, BUSY_M1, ABORT_M0, ABORT_M1};
  - `GRANT_NONE`/`GRANT_M0`/`GRANT_M1` constants;
  - the default address/data widths.
- One sub-module, `avalon_port_mux`: purely combinational selection of the request and response signals by grant. The arbiter itself holds the FSM, the `last` pointer and the watchdog.

## Test plan
- **Single M0 read, 0-wait slave:**
  - stimulus: M0 reads 0xBFC00000, RAM returns 0x3C020005;
  - required: `grant` = 01 one cycle later; M0 samples 0x3C020005 at the 2nd edge; `grant` = 00 after.
- **Simultaneous requests after reset:** M0 read 0xBFC00004 and M1 read 0xBFC00400 → M0 is served first, then M1. M1 `waitrequest` stays high throughout M0's transaction.
- **Round-robin:** both masters request continuously for 6 transactions → grant order M0, M1, M0, M1, M0, M1.
- **Wait states:**
  - stimulus: slave holds `waitrequest` high 3 cycles on an M1 write (0xBFC00408 ← 0xDEADBEEF, byteenable 1111);
  - required: `s_*` stable all 4 BUSY cycles; exactly one write completes.
- **Watchdog with `MAX_WAIT` = 4:**
  - stimulus: slave holds `waitrequest` high forever;
  - required: M0 `waitrequest` drops 5 cycles after grant with `readdata` 0; `timeout_err` = 1 and stays 1; the next M1 request is still served.
- **Reset mid-BUSY:** reset during an M0 wait state → the next cycle is IDLE, `s_read` = 0, `grant` = 00, `timeout_err` = 0.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the two-master Avalon-MM arbiter around the
// mips_cpu_bus / RAM_32x64k_avalon system.
//   - default address and data widths
//   - arbiter state encoding (BUSY and its ABORT sub-phase per master)
//   - one-hot grant codes and a state-to-grant helper
package mips_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUSY_M0  = 3'd1,
    BUSY_M1  = 3'd2,
    ABORT_M0 = 3'd3,
    ABORT_M1 = 3'd4
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // The abort cycle still belongs to the master whose transaction it ends.
  function automatic logic [1:0] grant_of(arb_state_t s);
    case (s)
      BUSY_M0, ABORT_M0: return GRANT_M0;
      BUSY_M1, ABORT_M1: return GRANT_M1;
      default:           return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/avalon_port_mux.sv
// Combinational request/response steering between two Avalon-MM masters
// and one slave.
//   grant      : one-hot owner (01 = M0, 10 = M1, 00 = nobody)
//   abort      : owner's transaction is being terminated by the watchdog
//   m0_*, m1_* : master requests in, waitrequest/readdata out
//   s_*        : slave request out, waitrequest/readdata in
// With no owner, or while aborting, nothing is strobed into the slave.
// A non-owner always sees waitrequest high and readdata zero.
module avalon_port_mux
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]          grant,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_waitrequest = 1'b1;
    m1_readdata    = '0;

    if (grant == GRANT_M0) begin
      if (abort) begin
        m0_waitrequest = 1'b0;
      end else begin
        s_address      = m0_address;
        // read+write together is treated as a write
        s_read         = m0_read & ~m0_write;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
      end
    end else if (grant == GRANT_M1) begin
      if (abort) begin
        m1_waitrequest = 1'b0;
      end else begin
        s_address      = m1_address;
        s_read         = m1_read & ~m1_write;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
      end
    end
  end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter. M0 is the CPU bus, M1 a debug
// or loader master; both share one RAM slave.
//   clk, reset    : single clock, synchronous active-high reset
//   m0_*, m1_*    : master ports (address/read/write/writedata/byteenable
//                   in, waitrequest/readdata out)
//   s_*           : slave port
//   grant         : registered one-hot owner, 00 when idle
//   timeout_err   : sticky watchdog-abort flag, cleared only by reset
// Whole transactions are granted round-robin through an IDLE cycle, and a
// watchdog ends any transaction whose slave stalls for MAX_WAIT cycles.
module avalon_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam logic [15:0] MAX_WAIT_C = 16'(MAX_WAIT);

  arb_state_t  state_q, state_d;
  logic        last_q, last_d;          // 1 = M1 was granted last
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] wait_cnt_inc;
  logic        timeout_err_q, timeout_err_d;
  logic        m0_req, m1_req, cur_req;
  logic        abort;

  assign m0_req  = m0_read | m0_write;
  assign m1_req  = m1_read | m1_write;
  assign cur_req = (state_q == BUSY_M1) ? m1_req : m0_req;

  assign wait_cnt_inc = wait_cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (m0_req && m1_req) begin
          state_d = last_q ? BUSY_M0 : BUSY_M1;
        end else if (m0_req) begin
          state_d = BUSY_M0;
        end else if (m1_req) begin
          state_d = BUSY_M1;
        end
      end

      BUSY_M0, BUSY_M1: begin
        if (!cur_req) begin
          // Owner withdrew mid-transaction: release without crediting it.
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (!s_waitrequest) begin
          state_d    = IDLE;
          last_d     = (state_q == BUSY_M1);
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          // Enter ABORT on the edge the count reaches MAX_WAIT, so the
          // master sees waitrequest low MAX_WAIT+1 cycles after grant.
          if (wait_cnt_inc == MAX_WAIT_C) begin
            state_d = (state_q == BUSY_M1) ? ABORT_M1 : ABORT_M0;
          end
        end
      end

      ABORT_M0, ABORT_M1: begin
        state_d       = IDLE;
        last_d        = (state_q == ABORT_M1);
        wait_cnt_d    = '0;
        timeout_err_d = 1'b1;
      end

      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_of(state_q);
  assign abort       = (state_q == ABORT_M0) || (state_q == ABORT_M1);
  assign timeout_err = timeout_err_q;

  avalon_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .grant          (grant),
    .abort          (abort),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_byteenable  (m0_byteenable),
    .m0_waitrequest (m0_waitrequest),
    .m0_readdata    (m0_readdata),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_byteenable  (m1_byteenable),
    .m1_waitrequest (m1_waitrequest),
    .m1_readdata    (m1_readdata),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata)
  );

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed testbench for avalon_bus_arbiter with MAX_WAIT = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
module tb_avalon_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic [3:0]    m0_byteenable = '0, m1_byteenable = '0;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] s_address;
  logic          s_read, s_write;
  logic [DW-1:0] s_writedata;
  logic [3:0]    s_byteenable;
  logic          s_waitrequest = 1'b0;
  logic [DW-1:0] s_readdata = '0;
  logic [1:0]    grant;
  logic          timeout_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int wr_count = 0;
  int wr_base;

  avalon_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_byteenable  (m0_byteenable),
    .m0_waitrequest (m0_waitrequest),
    .m0_readdata    (m0_readdata),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_byteenable  (m1_byteenable),
    .m1_waitrequest (m1_waitrequest),
    .m1_readdata    (m1_readdata),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata),
    .grant          (grant),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Slave-side view: a write is accepted on an edge with waitrequest low.
  always @(posedge clk) begin
    if (!reset && s_write && !s_waitrequest) wr_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state + single M0 read ----------------
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_grant",    grant, 2'b00);
    check("rst_s_strb",   {s_read, s_write}, 2'b00);
    check("rst_s_addr",   s_address, 32'h0);
    check("rst_waits",    {m0_waitrequest, m1_waitrequest}, 2'b11);
    check("rst_rdata",    {m0_readdata, m1_readdata}, 64'h0);
    check("rst_timeout",  timeout_err, 1'b0);

    m0_address    = 32'hBFC00000;
    m0_read       = 1'b1;
    s_waitrequest = 1'b0;
    s_readdata    = 32'h3C020005;
    tick();
    @(negedge clk);
    check("t1_grant",     grant, 2'b01);
    check("t1_s_read",    s_read, 1'b1);
    check("t1_s_addr",    s_address, 32'hBFC00000);
    check("t1_m0_wait",   m0_waitrequest, 1'b0);
    check("t1_m0_rdata",  m0_readdata, 32'h3C020005);
    check("t1_m1_resp",   {m1_waitrequest, m1_readdata}, {1'b1, 32'h0});
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    check("t1_done_grant", grant, 2'b00);
    check("t1_done_sread", s_read, 1'b0);

    // ---------------- simultaneous requests after reset ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m0_address = 32'hBFC00004; m0_read = 1'b1;
    m1_address = 32'hBFC00400; m1_read = 1'b1;
    s_readdata = 32'h11110000;
    tick();
    @(negedge clk);
    check("t2_first_grant", grant, 2'b01);
    check("t2_m0_addr",     s_address, 32'hBFC00004);
    check("t2_m1_wait_a",   m1_waitrequest, 1'b1);
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    check("t2_gap_grant",   grant, 2'b00);
    check("t2_m1_wait_b",   m1_waitrequest, 1'b1);
    tick();
    @(negedge clk);
    check("t2_second_grant", grant, 2'b10);
    check("t2_m1_addr",      s_address, 32'hBFC00400);
    check("t2_m1_rdata",     {m1_waitrequest, m1_readdata}, {1'b0, 32'h11110000});
    tick();
    m1_read = 1'b0;

    // ---------------- round-robin under continuous contention ----------------
    m0_read = 1'b1;
    m1_read = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("rr_grant_%0d", i), grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (i == 5) begin
        m0_read = 1'b0;
        m1_read = 1'b0;
      end
      @(negedge clk);
      check($sformatf("rr_idle_%0d", i), grant, 2'b00);
    end

    // ---------------- M1 write with three wait states ----------------
    m1_address    = 32'hBFC00408;
    m1_writedata  = 32'hDEADBEEF;
    m1_byteenable = 4'b1111;
    m1_write      = 1'b1;
    s_waitrequest = 1'b1;
    wr_base       = wr_count;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) s_waitrequest = 1'b0;
      @(negedge clk);
      check($sformatf("ws_grant_%0d", k), grant, 2'b10);
      check($sformatf("ws_strb_%0d", k), {s_read, s_write}, 2'b01);
      check($sformatf("ws_addr_data_%0d", k), {s_address, s_writedata}, {32'hBFC00408, 32'hDEADBEEF});
      check($sformatf("ws_be_%0d", k), s_byteenable, 4'b1111);
      check($sformatf("ws_m1_wait_%0d", k), m1_waitrequest, (k < 3) ? 1'b1 : 1'b0);
    end
    tick();
    m1_write = 1'b0;
    @(negedge clk);
    check("ws_write_count", 64'(wr_count - wr_base), 64'd1);
    check("ws_idle_strb",   {grant, s_write}, 3'b000);

    // ---------------- watchdog abort (MAX_WAIT = 4) ----------------
    m0_address    = 32'hBFC00010;
    m0_read       = 1'b1;
    s_waitrequest = 1'b1;
    s_readdata    = 32'h12345678;
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("wd_grant_%0d", k), grant, 2'b01);
      check($sformatf("wd_m0_wait_%0d", k), m0_waitrequest, (k < 4) ? 1'b1 : 1'b0);
      if (k == 4) begin
        check("wd_abort_rdata", m0_readdata, 32'h0);
        check("wd_abort_sread", s_read, 1'b0);
        check("wd_abort_err",   timeout_err, 1'b0);
      end
    end
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    check("wd_err_set",  timeout_err, 1'b1);
    check("wd_idle",     grant, 2'b00);
    m1_address    = 32'hBFC00020;
    m1_read       = 1'b1;
    s_waitrequest = 1'b0;
    tick();
    @(negedge clk);
    check("wd_m1_grant", grant, 2'b10);
    check("wd_m1_resp",  {m1_waitrequest, m1_readdata}, {1'b0, 32'h12345678});
    tick();
    m1_read = 1'b0;
    @(negedge clk);
    check("wd_err_sticky", timeout_err, 1'b1);

    // ---------------- reset during an M0 wait state ----------------
    m0_read       = 1'b1;
    s_waitrequest = 1'b1;
    tick();
    @(negedge clk);
    check("rb_grant", grant, 2'b01);
    check("rb_sread", s_read, 1'b1);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    m0_read = 1'b0;
    @(negedge clk);
    check("rb_grant_after", grant, 2'b00);
    check("rb_sread_after", s_read, 1'b0);
    check("rb_err_after",   timeout_err, 1'b0);
    check("rb_m0_wait",     m0_waitrequest, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
